enemy_pursuit_fsm: RTL

//  Parametrised enemy car controller for the scrolling Rally-X map.

---
 rtl/enemy_pursuit_fsm.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/enemy_pursuit_fsm.sv
// Enemy car controller: chases the player or returns to spawn on a timed schedule,
// recovers from wall hits through TURN, and holds while the player is caught.
module enemy_pursuit_fsm #(
  parameter int START_X        = 320,
  parameter int START_Y        = 440,
  parameter int VELOCITY       = 1,
  parameter int MAP_W          = 1280,
  parameter int MAP_H          = 960,
  parameter int SIZE           = 16,
  parameter int DEADZONE       = 4,
  parameter int TURN_FRAMES    = 8,
  parameter int CHASE_FRAMES   = 420,
  parameter int SCATTER_FRAMES = 120
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        enable,
  input  logic [10:0] player_x,
  input  logic [10:0] player_y,
  input  logic [4:0]  wall_hit,
  output logic [10:0] enemy_x,
  output logic [10:0] enemy_y,
  output logic [3:0]  enemy_dir,
  output logic        mode,
  output logic        caught
);

  typedef enum logic [1:0] {CHASE, SCATTER, TURN, HOLD} state_t;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  localparam logic signed [12:0] X_MIN = 13'(SIZE);
  localparam logic signed [12:0] X_MAX = 13'(MAP_W - 1 - SIZE);
  localparam logic signed [12:0] Y_MIN = 13'(SIZE);
  localparam logic signed [12:0] Y_MAX = 13'(MAP_H - 1 - SIZE);
  localparam logic signed [12:0] VEL   = 13'(VELOCITY);
  localparam logic [11:0]        DZ    = 12'(DEADZONE);
  localparam logic [11:0]        DZ2   = 12'(2 * DEADZONE);
  localparam logic [10:0]        HOME_X = 11'(START_X);
  localparam logic [10:0]        HOME_Y = 11'(START_Y);
  localparam logic [15:0]        TURN_LAST    = 16'(TURN_FRAMES - 1);
  localparam logic [15:0]        CHASE_LAST   = 16'(CHASE_FRAMES - 1);
  localparam logic [15:0]        SCATTER_LAST = 16'(SCATTER_FRAMES - 1);

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [3:0]  dir_q, dir_d;
  logic        mode_q, mode_d;
  logic        caught_q, caught_d;
  logic [15:0] turn_cnt_q, turn_cnt_d;
  logic [15:0] mode_cnt_q, mode_cnt_d;

  // Differences are taken in 12-bit signed so a target left/above the enemy stays negative.
  function automatic logic signed [11:0] delta(input logic [10:0] to, input logic [10:0] from);
    return $signed({1'b0, to}) - $signed({1'b0, from});
  endfunction

  function automatic logic [11:0] mag(input logic signed [11:0] v);
    return v[11] ? 12'(-v) : 12'(v);
  endfunction

  function automatic logic [3:0] rotate_cw(input logic [3:0] d);
    case (d)
      DIR_UP:    return DIR_RIGHT;
      DIR_RIGHT: return DIR_DOWN;
      DIR_DOWN:  return DIR_LEFT;
      default:   return DIR_UP;
    endcase
  endfunction

  function automatic logic signed [12:0] step_x(input logic [3:0] d);
    case (d)
      DIR_RIGHT: return VEL;
      DIR_LEFT:  return -VEL;
      default:   return 13'sd0;
    endcase
  endfunction

  function automatic logic signed [12:0] step_y(input logic [3:0] d);
    case (d)
      DIR_DOWN: return VEL;
      DIR_UP:   return -VEL;
      default:  return 13'sd0;
    endcase
  endfunction

  function automatic logic [10:0] clamp(input logic signed [12:0] v,
                                        input logic signed [12:0] lo,
                                        input logic signed [12:0] hi);
    if (v < lo) return lo[10:0];
    if (v > hi) return hi[10:0];
    return v[10:0];
  endfunction

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= CHASE;
      x_q        <= HOME_X;
      y_q        <= HOME_Y;
      dir_q      <= DIR_DOWN;
      mode_q     <= 1'b0;
      caught_q   <= 1'b0;
      turn_cnt_q <= '0;
      mode_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      mode_q     <= mode_d;
      caught_q   <= caught_d;
      turn_cnt_q <= turn_cnt_d;
      mode_cnt_q <= mode_cnt_d;
    end
  end

  logic signed [11:0] pdx, pdy, dx, dy;
  logic [11:0]        apdx, apdy, adx, ady;
  logic [10:0]        tx, ty;
  logic [3:0]         steer_dir, move_dir;
  logic               steer_move, do_move, caught_hit, released, out_of_range;
  logic signed [12:0] cand_x, cand_y, back_x, back_y;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_d      = dir_q;
    mode_d     = mode_q;
    caught_d   = caught_q;
    turn_cnt_d = turn_cnt_q;
    mode_cnt_d = mode_cnt_q;

    pdx  = delta(player_x, x_q);
    pdy  = delta(player_y, y_q);
    apdx = mag(pdx);
    apdy = mag(pdy);
    caught_hit = (apdx <= DZ) && (apdy <= DZ);
    released   = (apdx > DZ2) || (apdy > DZ2);

    tx  = (state_q == SCATTER) ? HOME_X : player_x;
    ty  = (state_q == SCATTER) ? HOME_Y : player_y;
    dx  = delta(tx, x_q);
    dy  = delta(ty, y_q);
    adx = mag(dx);
    ady = mag(dy);

    steer_dir  = dir_q;
    steer_move = 1'b0;
    if ((adx >= ady) && (adx > DZ)) begin
      steer_dir  = dx[11] ? DIR_LEFT : DIR_RIGHT;
      steer_move = 1'b1;
    end else if (ady > DZ) begin
      steer_dir  = dy[11] ? DIR_UP : DIR_DOWN;
      steer_move = 1'b1;
    end

    move_dir = (state_q == TURN) ? dir_q : steer_dir;
    do_move  = (state_q == TURN) || steer_move;
    cand_x   = $signed({2'b00, x_q}) + (do_move ? step_x(move_dir) : 13'sd0);
    cand_y   = $signed({2'b00, y_q}) + (do_move ? step_y(move_dir) : 13'sd0);
    back_x   = $signed({2'b00, x_q}) - step_x(dir_q);
    back_y   = $signed({2'b00, y_q}) - step_y(dir_q);
    out_of_range = (cand_x < X_MIN) || (cand_x > X_MAX) ||
                   (cand_y < Y_MIN) || (cand_y > Y_MAX);

    if (enable) begin
      if (caught_hit) begin
        state_d  = HOLD;
        caught_d = 1'b1;
      end else if (state_q == HOLD) begin
        if (released) begin
          state_d  = CHASE;
          caught_d = 1'b0;
        end
      end else if (wall_hit != 5'd0) begin
        x_d        = clamp(back_x, X_MIN, X_MAX);
        y_d        = clamp(back_y, Y_MIN, Y_MAX);
        dir_d      = rotate_cw(dir_q);
        state_d    = TURN;
        turn_cnt_d = '0;
      end else if (out_of_range) begin
        x_d        = clamp(cand_x, X_MIN, X_MAX);
        y_d        = clamp(cand_y, Y_MIN, Y_MAX);
        dir_d      = rotate_cw(move_dir);
        state_d    = TURN;
        turn_cnt_d = '0;
      end else begin
        x_d   = cand_x[10:0];
        y_d   = cand_y[10:0];
        dir_d = move_dir;
        if (state_q == TURN) begin
          if (turn_cnt_q == TURN_LAST) begin
            state_d    = mode_q ? SCATTER : CHASE;
            turn_cnt_d = '0;
          end else begin
            turn_cnt_d = turn_cnt_q + 16'd1;
          end
        end
      end

      // A mode flip only redirects the steering states; TURN and HOLD finish on their own.
      if (state_q != HOLD) begin
        if (mode_cnt_q == (mode_q ? SCATTER_LAST : CHASE_LAST)) begin
          mode_d     = ~mode_q;
          mode_cnt_d = '0;
          if ((state_d == CHASE) || (state_d == SCATTER))
            state_d = mode_d ? SCATTER : CHASE;
        end else begin
          mode_cnt_d = mode_cnt_q + 16'd1;
        end
      end
    end
  end

  always_comb begin
    enemy_x   = x_q;
    enemy_y   = y_q;
    enemy_dir = dir_q;
    mode      = mode_q;
    caught    = caught_q;
  end

endmodule
